// File: rtl/tiny_tpu_top.sv
`default_nettype none
// ============================================================================
// tiny_tpu_top : weight-stationary 2x2 systolic MAC array with weight memory
//                and a 64-word unified result buffer.
// Rev 1.0
// ============================================================================
module tiny_tpu_top #(
    parameter int MEM_DEPTH = 64,
    parameter int DATA_W    = 16,
    parameter int ACC_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       instruction,
    input  logic              valid,
    input  logic [DATA_W-1:0] a_in1,
    input  logic [DATA_W-1:0] a_in2,
    output logic [ACC_W-1:0]  unified_mem [MEM_DEPTH]
);

    localparam int       AW           = $clog2(MEM_DEPTH);
    localparam logic [2:0] OP_LOAD_ADDR = 3'b001;
    localparam logic [2:0] OP_LOAD_WGT  = 3'b010;
    localparam logic [2:0] OP_WRITE_WGT = 3'b011;
    localparam logic [2:0] CNT_SAT      = 3'd5;

    logic [2:0]        w_opcode;
    logic [12:0]       w_operand;

    logic [AW-1:0]     base_q;
    logic [2:0]        cnt_q;
    logic [DATA_W-1:0] wm_q   [MEM_DEPTH];
    logic [ACC_W-1:0]  mem_q  [MEM_DEPTH];
    logic [DATA_W-1:0] w_q    [2][2];
    logic [DATA_W-1:0] a_q    [2][2];
    logic [ACC_W-1:0]  p_q    [2][2];

    logic [DATA_W-1:0] a_left [2][2];
    logic [ACC_W-1:0]  p_above[2][2];
    logic [ACC_W-1:0]  p_d    [2][2];
    logic [AW-1:0]     w_idx  [4];

    assign w_opcode    = instruction[15:13];
    assign w_operand   = instruction[12:0];
    assign unified_mem = mem_q;

    // Activations flow right, partial sums flow down.
    always_comb begin
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 2; c++) begin
                if (c == 0) begin
                    a_left[r][c] = (r == 0) ? a_in1 : a_in2;
                end else begin
                    a_left[r][c] = a_q[r][0];
                end
                p_above[r][c] = (r == 0) ? '0 : p_q[0][c];
                p_d[r][c]     = p_above[r][c] + ACC_W'(a_left[r][c]) * ACC_W'(w_q[r][c]);
            end
        end
        for (int k = 0; k < 4; k++) begin
            w_idx[k] = base_q + AW'(k);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base_q <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < MEM_DEPTH; i++) begin
                wm_q[i]  <= DATA_W'(i);
                mem_q[i] <= '0;
            end
            for (int r = 0; r < 2; r++) begin
                for (int c = 0; c < 2; c++) begin
                    w_q[r][c] <= '0;
                    a_q[r][c] <= '0;
                    p_q[r][c] <= '0;
                end
            end
        end else if (valid) begin
            for (int r = 0; r < 2; r++) begin
                for (int c = 0; c < 2; c++) begin
                    a_q[r][c] <= a_left[r][c];
                    p_q[r][c] <= p_d[r][c];
                end
            end
            if (cnt_q != CNT_SAT) begin
                cnt_q <= cnt_q + 3'd1;
            end
            // Bottom-row psums leave the array skewed; capture each result once.
            case (cnt_q)
                3'd2: mem_q[0] <= p_q[1][0];
                3'd3: begin
                    mem_q[2] <= p_q[1][0];
                    mem_q[1] <= p_q[1][1];
                end
                3'd4: mem_q[3] <= p_q[1][1];
                default: ;
            endcase
        end else begin
            case (w_opcode)
                OP_LOAD_ADDR: base_q <= w_operand[AW-1:0];
                OP_LOAD_WGT: begin
                    w_q[0][0] <= wm_q[w_idx[0]];
                    w_q[0][1] <= wm_q[w_idx[1]];
                    w_q[1][0] <= wm_q[w_idx[2]];
                    w_q[1][1] <= wm_q[w_idx[3]];
                    cnt_q     <= '0;
                    for (int r = 0; r < 2; r++) begin
                        for (int c = 0; c < 2; c++) begin
                            a_q[r][c] <= '0;
                            p_q[r][c] <= '0;
                        end
                    end
                end
                OP_WRITE_WGT: begin
                    wm_q[base_q] <= DATA_W'(w_operand);
                    base_q       <= base_q + AW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tiny_tpu_top.sv
`default_nettype none
`timescale 1ns/1ps
// Randomized scoreboard bench for tiny_tpu_top against a matrix-level model.
module tb_tiny_tpu_top;

    localparam int MD = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] instruction;
    logic        valid;
    logic [15:0] a_in1, a_in2;
    logic [31:0] um [MD];

    always #5 clk = ~clk;

    tiny_tpu_top #(.MEM_DEPTH(64), .DATA_W(16), .ACC_W(32)) dut (
        .clk(clk), .reset(reset), .instruction(instruction), .valid(valid),
        .a_in1(a_in1), .a_in2(a_in2), .unified_mem(um)
    );

    typedef struct {
        int          addr;
        logic [31:0] val;
        int          tag;
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    event chk_ev;
    int   total = 0;
    int   bad   = 0;
    int   test_id = 0;

    // Reference model: weight memory, loaded tile, and per-run activation history.
    logic [15:0] m_wm  [MD];
    logic [31:0] m_mem [MD];
    logic [5:0]  m_base;
    logic [31:0] m_w11, m_w12, m_w21, m_w22;
    logic [31:0] m_a1 [3];
    logic [31:0] m_a2 [3];
    int          m_n;

    task automatic model_reset();
        for (int i = 0; i < MD; i++) begin
            m_wm[i]  = 16'(i);
            m_mem[i] = 32'd0;
        end
        m_base = 6'd0;
        m_w11 = 0; m_w12 = 0; m_w21 = 0; m_w22 = 0;
        m_n = 0;
    endtask

    task automatic model_instr(input logic [2:0] op, input logic [12:0] opnd);
        case (op)
            3'd1: m_base = opnd[5:0];
            3'd2: begin
                m_w11 = 32'(m_wm[m_base]);
                m_w12 = 32'(m_wm[6'(m_base + 6'd1)]);
                m_w21 = 32'(m_wm[6'(m_base + 6'd2)]);
                m_w22 = 32'(m_wm[6'(m_base + 6'd3)]);
                m_n   = 0;
            end
            3'd3: begin
                m_wm[m_base] = 16'(opnd);
                m_base       = m_base + 6'd1;
            end
            default: ;
        endcase
    endtask

    // C = A x W with A rows taken from the (pre-skewed) activation lanes.
    task automatic model_valid(input logic [15:0] a1, input logic [15:0] a2);
        if (m_n < 3) begin
            m_a1[m_n] = 32'(a1);
            m_a2[m_n] = 32'(a2);
        end
        if (m_n < 5) begin
            m_n = m_n + 1;
            if (m_n == 3) m_mem[0] = m_a1[0] * m_w11 + m_a2[1] * m_w21;
            if (m_n == 4) begin
                m_mem[1] = m_a1[0] * m_w12 + m_a2[1] * m_w22;
                m_mem[2] = m_a1[1] * m_w11 + m_a2[2] * m_w21;
            end
            if (m_n == 5) m_mem[3] = m_a1[1] * m_w12 + m_a2[2] * m_w22;
        end
    endtask

    task automatic do_instr(input logic [2:0] op, input logic [12:0] opnd);
        @(negedge clk);
        valid       = 1'b0;
        instruction = {op, opnd};
        @(posedge clk);
        model_instr(op, opnd);
    endtask

    task automatic do_valid(input logic [15:0] a1, input logic [15:0] a2, input logic [15:0] ins);
        @(negedge clk);
        valid       = 1'b1;
        instruction = ins;
        a_in1       = a1;
        a_in2       = a2;
        @(posedge clk);
        model_valid(a1, a2);
    endtask

    task automatic do_reset();
        @(negedge clk);
        valid       = 1'b0;
        instruction = 16'd0;
        reset       = 1'b1;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic expect_word(input int addr, input logic [31:0] v);
        sbq.push_back('{addr, v, test_id});
    endtask

    task automatic check_all();
        @(negedge clk);
        valid       = 1'b0;
        instruction = 16'd0;
        for (int i = 0; i < MD; i++) sbq.push_back('{i, m_mem[i], test_id});
        ->chk_ev;
        for (int k = 0; k < 8 && sbq.size() != 0; k++) @(negedge clk);
        if (sbq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain test%0d actual=%0d pending required=0", test_id, sbq.size());
            sbq.delete();
        end
    endtask

    initial begin
        forever begin
            @(chk_ev);
            #1;
            while (sbq.size() > 0) begin
                e = sbq.pop_front();
                total++;
                if (um[e.addr] !== e.val) begin
                    bad++;
                    $display("FAIL mem[%0d] test%0d actual=%0d required=%0d",
                             e.addr, e.tag, um[e.addr], e.val);
                end
            end
        end
    end

    initial begin
        logic [15:0] a1v [7];
        logic [15:0] a2v [7];
        reset = 1'b1; valid = 1'b0; instruction = 16'd0; a_in1 = 0; a_in2 = 0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;

        test_id = 1;
        check_all();

        test_id = 2;
        a1v = '{16'd11, 16'd12, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        a2v = '{16'd0, 16'd21, 16'd22, 16'd0, 16'd0, 16'd0, 16'd0};
        do_instr(3'd1, 13'd15);
        do_instr(3'd2, 13'd0);
        for (int i = 0; i < 7; i++) do_valid(a1v[i], a2v[i], {3'd2, 13'd0});
        expect_word(0, 522); expect_word(1, 554); expect_word(2, 554); expect_word(3, 588);
        check_all();

        test_id = 3;
        do_instr(3'd1, 13'd0);
        for (int i = 1; i <= 4; i++) do_instr(3'd3, 13'(i));
        do_instr(3'd1, 13'd0);
        do_instr(3'd2, 13'd0);
        do_valid(1, 0, 0); do_valid(2, 3, 0); do_valid(0, 4, 0); do_valid(0, 0, 0); do_valid(0, 0, 0);
        expect_word(0, 10); expect_word(1, 14); expect_word(2, 14); expect_word(3, 20);
        check_all();

        test_id = 4;
        do_instr(3'd1, 13'd62);
        do_instr(3'd2, 13'd0);
        do_valid(1, 0, 0);
        for (int i = 0; i < 4; i++) do_valid(0, 0, 0);
        expect_word(0, 62); expect_word(1, 63); expect_word(2, 0); expect_word(3, 0);
        check_all();

        test_id = 5;
        do_instr(3'd1, 13'd15);
        do_instr(3'd2, 13'd0);
        for (int i = 0; i < 7; i++) begin
            do_valid(a1v[i], a2v[i], 16'd0);
            repeat (1 + (i % 2)) do_instr(3'd0, 13'd0);
        end
        expect_word(0, 522); expect_word(1, 554); expect_word(2, 554); expect_word(3, 588);
        check_all();

        test_id = 6;
        do_instr(3'd1, 13'd15);
        do_instr(3'd3, 13'd99);
        do_instr(3'd1, 13'd15);
        do_instr(3'd2, 13'd0);
        for (int i = 0; i < 3; i++) do_valid(a1v[i], a2v[i], 16'd0);
        do_reset();
        check_all();
        do_instr(3'd1, 13'd15);
        do_instr(3'd2, 13'd0);
        for (int i = 0; i < 7; i++) do_valid(a1v[i], a2v[i], 16'd0);
        expect_word(0, 522); expect_word(1, 554); expect_word(2, 554); expect_word(3, 588);
        check_all();

        for (int it = 0; it < 20; it++) begin
            int nw, nv, r;
            logic [2:0] sop;
            test_id = 100 + it;
            do_instr(3'd1, 13'($urandom_range(0, 63)));
            nw = $urandom_range(0, 4);
            for (int k = 0; k < nw; k++) do_instr(3'd3, 13'($urandom));
            do_instr(3'd1, 13'($urandom));
            do_instr(3'd2, 13'($urandom));
            nv = 5 + $urandom_range(0, 2);
            for (int k = 0; k < nv; k++) begin
                do_valid(16'($urandom), 16'($urandom), 16'($urandom));
                repeat ($urandom_range(0, 2)) begin
                    r   = $urandom_range(0, 6);
                    sop = (r == 2) ? 3'd3 : ((r >= 3) ? 3'(r + 1) : 3'(r));
                    do_instr(sop, 13'($urandom));
                end
            end
            check_all();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
